icache_data_sram_arbiter: RTL and testbench

- Shares one single-port L1.5 icache data SRAM between two requesters:
  - the lookup read path (fetch hits);
  - the refill write path (line fills from L2).
- Sits directly in front of the data SRAM wrapper and drives its req/we/addr/wdata/be.
- Adds a one-entry read-response hold buffer so the read consumer can stall.
- Adds a bounded-starvation write-priority policy so refills cannot lock out lookups indefinitely.

---
 rtl/icache_data_sram_arbiter.sv | 110 +++++++++++
 tb/tb_icache_data_sram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_data_sram_arbiter.sv
// icache_data_sram_arbiter
// Shares the single-port L1.5 icache data SRAM between the lookup read path
// and the refill write path. A one-entry hold buffer lets the read consumer
// stall, and a write-streak limit stops refills from locking out lookups.
module icache_data_sram_arbiter #(
  parameter  int unsigned NumWords   = 256,
  parameter  int unsigned DataWidth  = 128,
  parameter  int unsigned MaxWrBurst = 4,
  localparam int unsigned AddrWidth  = $clog2(NumWords),
  localparam int unsigned BeWidth    = (DataWidth + 7) / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rd_req_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic                 rd_gnt_o,
  output logic                 rd_rvalid_o,
  output logic [DataWidth-1:0] rd_rdata_o,
  input  logic                 rd_rready_i,
  input  logic                 wr_req_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [DataWidth-1:0] wr_wdata_i,
  input  logic [BeWidth-1:0]   wr_be_i,
  output logic                 wr_gnt_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [BeWidth-1:0]   mem_be_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  logic                 r_inflight;
  logic                 r_hold_valid;
  logic [DataWidth-1:0] r_hold_data;
  logic [3:0]           r_streak;

  logic                 w_rd_ok;
  logic                 w_burst_done;
  logic                 w_rd_gnt;
  logic                 w_wr_gnt;

  // Arbitration: a read may go only if its response has somewhere to land;
  // writes win a conflict until they have used up their burst allowance.
  always_comb begin
    w_rd_ok      = rd_req_i & ~r_hold_valid & (~r_inflight | rd_rready_i);
    w_burst_done = (r_streak == 4'(MaxWrBurst));
    w_wr_gnt     = wr_req_i & ~(w_rd_ok & w_burst_done);
    w_rd_gnt     = w_rd_ok & ~w_wr_gnt;
  end

  // SRAM drive: the winning port steers the bus, idle cycles drive zeros.
  always_comb begin
    mem_req_o   = w_rd_gnt | w_wr_gnt;
    mem_we_o    = w_wr_gnt;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (w_wr_gnt) begin
      mem_addr_o  = wr_addr_i;
      mem_wdata_o = wr_wdata_i;
      mem_be_o    = wr_be_i;
    end else if (w_rd_gnt) begin
      mem_addr_o  = rd_addr_i;
      mem_be_o    = '1;
    end
  end

  // Response path: held data has priority, otherwise pass the SRAM output through.
  always_comb begin
    rd_gnt_o    = w_rd_gnt;
    wr_gnt_o    = w_wr_gnt;
    rd_rvalid_o = r_inflight | r_hold_valid;
    rd_rdata_o  = '0;
    if (r_hold_valid) begin
      rd_rdata_o = r_hold_data;
    end else if (r_inflight) begin
      rd_rdata_o = mem_rdata_i;
    end
  end

  // Track the in-flight read and park its data when the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inflight   <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else begin
      r_inflight <= w_rd_gnt;
      if (r_inflight && !rd_rready_i) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= mem_rdata_i;
      end else if (r_hold_valid && rd_rready_i) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  // Count writes that beat an eligible read; any read grant or idle read side resets it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_streak <= 4'd0;
    end else if (!w_rd_ok || w_rd_gnt) begin
      r_streak <= 4'd0;
    end else if (w_wr_gnt && !w_burst_done) begin
      r_streak <= r_streak + 4'd1;
    end
  end

endmodule

// File: tb/tb_icache_data_sram_arbiter.sv
// tb_icache_data_sram_arbiter
// Directed bench with a response-slot reference model and an SRAM model.
module tb_icache_data_sram_arbiter;

  localparam int MaxWrBurst = 4;
  localparam logic [127:0] PatA5   = {16{8'hA5}};
  localparam logic [127:0] Pat20   = {4{32'h1234_5678}};
  localparam logic [127:0] Pat21   = {4{32'h8765_4321}};
  localparam logic [127:0] PatDead = {8{16'hDEAD}};

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b1;
  logic         rd_req_i = 1'b0;
  logic [7:0]   rd_addr_i = '0;
  logic         rd_gnt_o;
  logic         rd_rvalid_o;
  logic [127:0] rd_rdata_o;
  logic         rd_rready_i = 1'b1;
  logic         wr_req_i = 1'b0;
  logic [7:0]   wr_addr_i = '0;
  logic [127:0] wr_wdata_i = '0;
  logic [15:0]  wr_be_i = '0;
  logic         wr_gnt_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [7:0]   mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [15:0]  mem_be_o;
  logic [127:0] mem_rdata_i;

  int vecCount = 0;
  int missCount = 0;

  icache_data_sram_arbiter #(
    .NumWords(256), .DataWidth(128), .MaxWrBurst(MaxWrBurst)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .rd_rvalid_o(rd_rvalid_o), .rd_rdata_o(rd_rdata_o), .rd_rready_i(rd_rready_i),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_wdata_i(wr_wdata_i),
    .wr_be_i(wr_be_i), .wr_gnt_o(wr_gnt_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Power-up contents shared by the SRAM model and the reference model.
  function automatic logic [127:0] initWord(input int i);
    case (i)
      'h10:    return PatA5;
      'h20:    return Pat20;
      'h21:    return Pat21;
      default: return {16{8'(i)}};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdReq, input logic [7:0] rdAddr, input logic rdy,
                               input logic wrReq, input logic [7:0] wrAddr,
                               input logic [127:0] wdata, input logic [15:0] be);
    @(posedge clk_i);
    #1;
    rd_req_i    = rdReq;
    rd_addr_i   = rdAddr;
    rd_rready_i = rdy;
    wr_req_i    = wrReq;
    wr_addr_i   = wrAddr;
    wr_wdata_i  = wdata;
    wr_be_i     = be;
    @(negedge clk_i);
  endtask

  task automatic idleCycle(input logic rdy);
    applyStimulus(1'b0, 8'h00, rdy, 1'b0, 8'h00, '0, '0);
  endtask

  // Single-port SRAM with one-cycle read latency and byte-enabled writes.
  logic [127:0] sramMem [256];
  logic [127:0] sramRdata;
  assign mem_rdata_i = sramRdata;

  initial begin
    for (int i = 0; i < 256; i++) sramMem[i] <= initWord(i);
    sramRdata <= '0;
    forever begin
      @(posedge clk_i);
      if (mem_req_o) begin
        if (mem_we_o) begin
          for (int b = 0; b < 16; b++)
            if (mem_be_o[b]) sramMem[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
        end else begin
          sramRdata <= sramMem[mem_addr_o];
        end
      end
    end
  end

  // Reference model: one response slot, a write-run counter and a shadow memory.
  logic [127:0] refMem [256];
  logic         mPendValid;
  logic         mPendFresh;
  logic [127:0] mPendData;
  int           mWrRun;
  logic         mRdOk;
  logic         mRd;
  logic         mWr;
  logic [7:0]   eAddr;
  logic [127:0] eWdata;
  logic [15:0]  eBe;

  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
    mPendValid = 1'b0;
    mPendFresh = 1'b0;
    mPendData  = '0;
    mWrRun     = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        mPendValid = 1'b0;
        mPendFresh = 1'b0;
        mWrRun     = 0;
        checkOutput("rst_rd_gnt", {127'd0, rd_gnt_o}, 128'd0);
        checkOutput("rst_wr_gnt", {127'd0, wr_gnt_o}, 128'd0);
        checkOutput("rst_mem_req", {127'd0, mem_req_o}, 128'd0);
        checkOutput("rst_rvalid", {127'd0, rd_rvalid_o}, 128'd0);
        checkOutput("rst_rdata", rd_rdata_o, 128'd0);
      end else begin
        mRdOk = rd_req_i && (!mPendValid || (mPendFresh && rd_rready_i));
        mWr   = wr_req_i && !(mRdOk && mWrRun == MaxWrBurst);
        mRd   = mRdOk && !mWr;
        eAddr  = mWr ? wr_addr_i : (mRd ? rd_addr_i : 8'h00);
        eWdata = mWr ? wr_wdata_i : '0;
        eBe    = mWr ? wr_be_i : (mRd ? 16'hFFFF : 16'h0000);
        checkOutput("rd_gnt", {127'd0, rd_gnt_o}, {127'd0, mRd});
        checkOutput("wr_gnt", {127'd0, wr_gnt_o}, {127'd0, mWr});
        checkOutput("mem_req", {127'd0, mem_req_o}, {127'd0, mRd | mWr});
        checkOutput("mem_we", {127'd0, mem_we_o}, {127'd0, mWr});
        checkOutput("mem_addr", {120'd0, mem_addr_o}, {120'd0, eAddr});
        checkOutput("mem_wdata", mem_wdata_o, eWdata);
        checkOutput("mem_be", {112'd0, mem_be_o}, {112'd0, eBe});
        checkOutput("rd_rvalid", {127'd0, rd_rvalid_o}, {127'd0, mPendValid});
        checkOutput("rd_rdata", rd_rdata_o, mPendValid ? mPendData : 128'd0);
        if (mPendValid && rd_rready_i) mPendValid = 1'b0;
        else mPendFresh = 1'b0;
        if (mRd) begin
          mPendValid = 1'b1;
          mPendFresh = 1'b1;
          mPendData  = refMem[rd_addr_i];
        end
        if (mWr) begin
          for (int b = 0; b < 16; b++)
            if (wr_be_i[b]) refMem[wr_addr_i][b*8 +: 8] = wr_wdata_i[b*8 +: 8];
        end
        if (mWr && mRdOk) mWrRun = (mWrRun < MaxWrBurst) ? mWrRun + 1 : mWrRun;
        else mWrRun = 0;
      end
    end
  end

  // Directed sequence with hand-computed literal expectations.
  initial begin
    logic expR;
    #1 rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_rvalid", {127'd0, rd_rvalid_o}, 128'd0);
    checkOutput("reset_mem_req", {127'd0, mem_req_o}, 128'd0);
    checkOutput("reset_rdata", rd_rdata_o, 128'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Single read of word 0x10.
    applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 8'h00, '0, '0);
    checkOutput("single_gnt", {127'd0, rd_gnt_o}, 128'd1);
    checkOutput("single_addr", {120'd0, mem_addr_o}, 128'h10);
    checkOutput("single_be", {112'd0, mem_be_o}, 128'hFFFF);
    idleCycle(1'b1);
    checkOutput("single_rvalid", {127'd0, rd_rvalid_o}, 128'd1);
    checkOutput("single_rdata", rd_rdata_o, PatA5);
    idleCycle(1'b1);
    checkOutput("single_rvalid_once", {127'd0, rd_rvalid_o}, 128'd0);

    // Stall three cycles with a second read pending.
    applyStimulus(1'b1, 8'h20, 1'b1, 1'b0, 8'h00, '0, '0);
    checkOutput("stall_gnt0", {127'd0, rd_gnt_o}, 128'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'h21, 1'b0, 1'b0, 8'h00, '0, '0);
      checkOutput("stall_rvalid", {127'd0, rd_rvalid_o}, 128'd1);
      checkOutput("stall_rdata", rd_rdata_o, Pat20);
      checkOutput("stall_no_gnt", {127'd0, rd_gnt_o}, 128'd0);
    end
    applyStimulus(1'b1, 8'h21, 1'b1, 1'b0, 8'h00, '0, '0);
    checkOutput("stall_release_rdata", rd_rdata_o, Pat20);
    checkOutput("stall_release_no_gnt", {127'd0, rd_gnt_o}, 128'd0);
    applyStimulus(1'b1, 8'h21, 1'b1, 1'b0, 8'h00, '0, '0);
    checkOutput("stall_next_gnt", {127'd0, rd_gnt_o}, 128'd1);
    checkOutput("stall_drained", {127'd0, rd_rvalid_o}, 128'd0);
    idleCycle(1'b1);
    checkOutput("stall_next_rdata", rd_rdata_o, Pat21);

    // Writes alone for eight cycles.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h40 + k), {4{32'hBEEF_0000 + 32'(k)}}, 16'hFFFF);
      checkOutput("wronly_gnt", {127'd0, wr_gnt_o}, 128'd1);
      checkOutput("wronly_we", {127'd0, mem_we_o}, 128'd1);
    end

    // Continuous contention: W,W,W,W,R repeating.
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1'b1, 8'h50, 1'b1, 1'b1, 8'(8'h60 + k), {4{32'hCAFE_0000 + 32'(k)}}, 16'hFFFF);
      expR = ((k % 5) == 4);
      checkOutput("burst_rd_gnt", {127'd0, rd_gnt_o}, {127'd0, expR});
      checkOutput("burst_wr_gnt", {127'd0, wr_gnt_o}, {127'd0, ~expR});
    end
    idleCycle(1'b1);

    // Write then read back, full and partial byte enables.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h03, PatDead, 16'hFFFF);
    checkOutput("coh_wr_gnt", {127'd0, wr_gnt_o}, 128'd1);
    applyStimulus(1'b1, 8'h03, 1'b1, 1'b0, 8'h00, '0, '0);
    idleCycle(1'b1);
    checkOutput("coh_rdata", rd_rdata_o, PatDead);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h04, {16{8'hEE}}, 16'h00FF);
    applyStimulus(1'b1, 8'h04, 1'b1, 1'b0, 8'h00, '0, '0);
    idleCycle(1'b1);
    checkOutput("coh_partial", rd_rdata_o, {{8{8'h04}}, {8{8'hEE}}});

    // Writes proceed while the hold buffer is full.
    applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 8'h00, '0, '0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h10, {16{8'h11}}, 16'hFFFF);
    checkOutput("hold_wr_gnt", {127'd0, wr_gnt_o}, 128'd1);
    checkOutput("hold_rdata0", rd_rdata_o, PatA5);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h11, {16{8'h22}}, 16'hFFFF);
    checkOutput("hold_rdata1", rd_rdata_o, PatA5);
    idleCycle(1'b1);
    checkOutput("hold_rdata2", rd_rdata_o, PatA5);
    applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 8'h00, '0, '0);
    idleCycle(1'b1);
    checkOutput("hold_new_rdata", rd_rdata_o, {16{8'h11}});

    // Reset while a response is held.
    applyStimulus(1'b1, 8'h21, 1'b1, 1'b0, 8'h00, '0, '0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("rst_pre_rvalid", {127'd0, rd_rvalid_o}, 128'd1);
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      checkOutput("rst_mid_rvalid", {127'd0, rd_rvalid_o}, 128'd0);
      checkOutput("rst_mid_mem_req", {127'd0, mem_req_o}, 128'd0);
      @(posedge clk_i);
    end
    #1 rst_ni = 1'b1;
    idleCycle(1'b1);
    checkOutput("rst_post_rvalid", {127'd0, rd_rvalid_o}, 128'd0);
    applyStimulus(1'b1, 8'h21, 1'b1, 1'b0, 8'h00, '0, '0);
    checkOutput("rst_post_gnt", {127'd0, rd_gnt_o}, 128'd1);
    idleCycle(1'b1);
    checkOutput("rst_post_rdata", rd_rdata_o, Pat21);
    idleCycle(1'b1);
    idleCycle(1'b1);

    @(posedge clk_i);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
